// File: rtl/fsm_4state_decoder_if.sv
// Encoded-bit input and decoded-word valid/ready bundle
// for the 4-state decoder.
interface fsm_4state_decoder_if #(
    parameter int WORD_W = 8
);
    logic              enc_valid;
    logic              enc_bit;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output enc_valid,
        output enc_bit,
        output word_ready,
        input  word_data,
        input  word_valid
    );

    modport slave (
        input  enc_valid,
        input  enc_bit,
        input  word_ready,
        output word_data,
        output word_valid
    );
endinterface

// File: rtl/fsm_4state_decoder.sv
// Receive side of the 4-state bit encoder: tracks the encoder state,
// recovers data bits and packs them into WORD_W-bit words.
module fsm_4state_decoder #(
    parameter  int WORD_W = 8,
    localparam int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    fsm_4state_decoder_if.slave  bus,
    output logic                 overflow,
    output logic [1:0]           model_state,
    output logic [CNT_W-1:0]     bit_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] full_word;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              dec_bit;
    logic              accept;
    logic              last;
    logic              consume;
    logic              load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // The encoder emits state[0]; state[1] is the XOR mask.
    always_comb begin
        dec_bit = bus.enc_bit ^ state_q[1];
        accept  = bus.enc_valid & ~sync;
        state_d = state_q;
        if (sync) begin
            state_d = S0;
        end else if (accept) begin
            unique case (state_q)
                S0: state_d = dec_bit ? S1 : S2;
                S1: state_d = dec_bit ? S3 : S0;
                S2: state_d = dec_bit ? S0 : S1;
                S3: state_d = dec_bit ? S2 : S3;
            endcase
        end
    end

    always_comb begin
        last      = accept && (cnt_q == CNT_W'(WORD_W - 1));
        consume   = valid_q & bus.word_ready;
        load      = last & (~valid_q | consume);
        full_word = shift_q;
        full_word[WORD_W-1] = dec_bit;
        shift_d   = shift_q;
        for (int i = 0; i < WORD_W; i++) begin
            if (accept && cnt_q == CNT_W'(i)) begin
                shift_d[i] = dec_bit;
            end
        end
        cnt_d = cnt_q;
        if (sync) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        word_d  = load ? full_word : word_q;
        valid_d = load ? 1'b1 : (consume ? 1'b0 : valid_q);
        // A completed word with nowhere to go is lost.
        ovf_d = ovf_q;
        if (sync) begin
            ovf_d = 1'b0;
        end else if (last && !load) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        model_state    = state_q;
        bit_cnt        = cnt_q;
        overflow       = ovf_q;
        bus.word_data  = word_q;
        bus.word_valid = valid_q;
    end

endmodule
